alu_frame_ctrl: RTL and testbench
=================================

# alu_frame_ctrl

Frame sequencer between the UART FIFOs and the ALU in the TP2 datapath. It pops a 3-byte frame from the RX FIFO: operand A, operand B, then opcode. It validates the opcode and presents registered operands to the ALU. It then pushes the ALU result byte into the TX FIFO. It replaces the separate RX/TX interface blocks with one state machine that owns both FIFO handshakes.

## Interface
- NBIT, 8: data/operand width.
- OPW, 6: opcode width; the opcode is taken from the low OPW bits of the third byte.
- TIMEOUT_CYC, 5_000_000: inter-byte timeout in CLK cycles. Used only when the timeout feature is compiled in.

- CLK, in, 1: system clock.
- RESET, in, 1: synchronous, active-low reset.
- rx_empty, in, 1: RX FIFO empty. The FIFO is first-word-fall-through, so r_data is valid whenever rx_empty=0.
- r_data, in, NBIT: RX FIFO head byte.
- rd_uart, out, 1: RX FIFO pop strobe, one cycle.
- tx_full, in, 1: TX FIFO full.
- w_data, out, NBIT: byte to TX FIFO.
- wr_uart, out, 1: TX FIFO push strobe, one cycle.
- alu_a, out, NBIT: registered operand A.
- alu_b, out, NBIT: registered operand B.
- alu_op, out, OPW: registered opcode.
- alu_res, in, NBIT: ALU result, combinational from alu_a/alu_b/alu_op.
- err, out, 1: one-cycle pulse on a rejected frame.
- err_cnt, out, 8: saturating count of rejected frames.
- state, out, 3: current state encoding, for LED debug.

## Operation
- States and encodings: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SEND=4.
- GET_A, GET_B, GET_OP:
  - If rx_empty=0: assert rd_uart for one cycle, capture r_data into the matching register, and advance.
  - If rx_empty=1: hold state; rd_uart=0.
- Valid opcodes:
  - ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25.
  - XOR 6'h26, NOR 6'h27, SRA 6'h03, SRL 6'h02.
- GET_OP with an invalid opcode:
  - The byte is still popped, alu_op is not updated, and no result is sent.
  - err pulses, err_cnt increments (saturating at 255), and the next state is GET_A.
- GET_OP with a valid opcode: capture into alu_op, next state EXEC.
- EXEC: one cycle. Latch alu_res into the result register that drives w_data, then go to SEND.
- SEND:
  - If tx_full=0: assert wr_uart for one cycle, then go to GET_A.
  - If tx_full=1: hold with wr_uart=0 and w_data stable.
  - No RX pops occur while in EXEC or SEND.
- alu_a, alu_b and alu_op hold their values until overwritten by the next frame.

## Timing
- Reset values (RESET=0 at a CLK edge):
  - state=GET_A, rd_uart=0, wr_uart=0, err=0, err_cnt=0.
  - alu_a=alu_b=0, alu_op=0, w_data=0.
- rd_uart and the capture occur in the same cycle.
- Back-to-back pops on consecutive cycles are legal; the next state samples the updated rx_empty.
- Latency: opcode pop in cycle t, EXEC in t+1, wr_uart in t+2 when tx_full=0.
- The minimum frame period is 5 cycles.
- rd_uart and wr_uart are never asserted in the same cycle.
- Reset mid-frame discards partial operands and the pending result. No strobe is issued in the reset cycle.

## Configuration
- Macro ALU_FRAME_TIMEOUT_EN.
- Defined:
  - In GET_B and GET_OP, a counter counts cycles with rx_empty=1. It clears on each pop and on entry to GET_A.
  - When it reaches TIMEOUT_CYC-1 with no pop, the partial frame is aborted: next state GET_A, err pulses, err_cnt increments.
  - GET_A never times out.
- Undefined: no counter is built, and the FSM waits indefinitely for each byte.

## Structure
- Shared package alu_frame_pkg holds:
  - the state enum and its encodings;
  - the opcode localparams;
  - the function is_valid_op.
- The ALU handler imports the opcode constants from this package.
- Sub-module frame_timer holds the timeout counter (clear, enable, expire). It is instantiated only under ALU_FRAME_TIMEOUT_EN.

## Test plan
- Frame 0x05, 0x03, 0x20 with the ALU model responding: wr_uart pulses once with w_data=0x08, two cycles after the opcode pop; state returns to 0.
- Frame 0x0F, 0xF0, 0x26 while tx_full=1 for 10 cycles: state holds at 4 with no wr_uart; after release, one push of 0xFF.
- Frame 0x01, 0x02, 0x3F: err pulses, err_cnt=1, no wr_uart, alu_op unchanged, state=0.
- Two frames preloaded (6 bytes): rd_uart on consecutive cycles within each frame; two pushes in order; the second push no earlier than 5 cycles after the first.
- RESET=0 asserted in GET_OP after two pops: all outputs take reset values; the next full frame is processed correctly.
- With ALU_FRAME_TIMEOUT_EN and TIMEOUT_CYC=16: send one byte then stall 16 cycles. The abort goes to GET_A with an err pulse; a new full frame then completes normally.

Source files
------------

// File: rtl/alu_frame_pkg.sv
// Shared types for the UART<->ALU frame sequencer: FSM states, opcode set, opcode check.
package alu_frame_pkg;

  localparam int OP_W = 6;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W-1:0] OP_AND = 6'h24;
  localparam logic [OP_W-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W-1:0] OP_NOR = 6'h27;
  localparam logic [OP_W-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W-1:0] OP_SRL = 6'h02;

  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_frame_ctrl_timer.sv
// Inter-byte timeout counter for alu_frame_ctrl; only built with ALU_FRAME_TIMEOUT_EN.
module frame_timer #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] cnt;

  assign expire = en && (cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (!RESET || clr) cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/alu_frame_ctrl.sv
// Pops A/B/opcode frames from the RX FIFO, drives registered ALU operands, pushes the result to TX.
// Optional inter-byte timeout abort under macro ALU_FRAME_TIMEOUT_EN.
module alu_frame_ctrl
  import alu_frame_pkg::*;
#(
  parameter int NBIT        = 8,
  parameter int OPW         = OP_W,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            rx_empty,
  input  logic [NBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic [NBIT-1:0] w_data,
  output logic            wr_uart,
  output logic [NBIT-1:0] alu_a,
  output logic [NBIT-1:0] alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [NBIT-1:0] alu_res,
  output logic            err,
  output logic [7:0]      err_cnt,
  output logic [2:0]      state
);

  if (TIMEOUT_CYC < 2) begin : g_cfg_chk
    $error("alu_frame_ctrl: TIMEOUT_CYC must be at least 2");
  end

  state_t          cur, nxt;
  logic [OPW-1:0]  op_in;
  logic            op_ok;
  logic            tmo_expire;
  logic [NBIT-1:0] res_q;

  assign op_in  = r_data[OPW-1:0];
  assign op_ok  = is_valid_op(OP_W'(op_in));
  assign state  = cur;
  assign w_data = res_q;

`ifdef ALU_FRAME_TIMEOUT_EN
  logic tmo_en, tmo_clr;

  // Only stalls on B/opcode count; any pop or idle GET_A restarts the window.
  assign tmo_en  = ((cur == GET_B) || (cur == GET_OP)) && rx_empty;
  assign tmo_clr = rd_uart || (cur == GET_A);

  frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  // Strobes are gated by RESET so nothing fires in a reset cycle.
  always_comb begin
    nxt     = cur;
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    err     = 1'b0;
    if (RESET) begin
      case (cur)
        GET_A: if (!rx_empty) begin
          rd_uart = 1'b1;
          nxt     = GET_B;
        end
        GET_B: if (!rx_empty) begin
          rd_uart = 1'b1;
          nxt     = GET_OP;
        end else if (tmo_expire) begin
          err = 1'b1;
          nxt = GET_A;
        end
        GET_OP: if (!rx_empty) begin
          rd_uart = 1'b1;
          if (op_ok) nxt = EXEC;
          else begin
            err = 1'b1;
            nxt = GET_A;
          end
        end else if (tmo_expire) begin
          err = 1'b1;
          nxt = GET_A;
        end
        EXEC: nxt = SEND;
        SEND: if (!tx_full) begin
          wr_uart = 1'b1;
          nxt     = GET_A;
        end
        default: nxt = GET_A;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cur     <= GET_A;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      res_q   <= '0;
      err_cnt <= '0;
    end else begin
      cur <= nxt;
      if (rd_uart && cur == GET_A)           alu_a  <= r_data;
      if (rd_uart && cur == GET_B)           alu_b  <= r_data;
      if (rd_uart && cur == GET_OP && op_ok) alu_op <= op_in;
      if (cur == EXEC)                       res_q  <= alu_res;
      if (err && err_cnt != 8'hFF)           err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Self-checking bench for alu_frame_ctrl: directed frames plus randomized frames vs a frame-level model.
module tb_alu_frame_ctrl;

  localparam int NBIT = 8;
  localparam int OPW  = 6;
  localparam int TO   = 16;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic            rx_empty = 1'b1;
  logic [NBIT-1:0] r_data = '0;
  logic            rd_uart, wr_uart, err;
  logic            tx_full = 1'b0;
  logic [NBIT-1:0] w_data, alu_a, alu_b, alu_res;
  logic [OPW-1:0]  alu_op;
  logic [7:0]      err_cnt;
  logic [2:0]      state;

  alu_frame_ctrl #(.NBIT(NBIT), .OPW(OPW), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RESET(RESET), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_res(alu_res), .err(err), .err_cnt(err_cnt), .state(state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  // External ALU the controller feeds.
  assign alu_res = alu_f(alu_a, alu_b, alu_op);

  logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  function automatic bit op_valid(input logic [7:0] byt);
    foreach (valid_ops[i]) if (byt[5:0] == valid_ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  int errors = 0, checks = 0, cyc = 0, err_ev = 0, both_ev = 0;
  logic [7:0] rxq[$];
  logic [7:0] wr_q[$];
  int         wr_cyc[$];
  int         rd_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
    upd_rx();
  endtask

  task automatic clr_logs();
    wr_q.delete(); wr_cyc.delete(); rd_cyc.delete();
  endtask

  // One clock: sample at negedge, FIFO model reacts just after posedge.
  task automatic tick();
    bit popped;
    @(negedge CLK);
    popped = rd_uart;
    if (rd_uart && wr_uart) both_ev++;
    if (wr_uart) begin wr_q.push_back(w_data); wr_cyc.push_back(cyc); end
    if (rd_uart) rd_cyc.push_back(cyc);
    if (err) err_ev++;
    @(posedge CLK);
    cyc++;
    #1;
    if (popped && rxq.size() > 0) void'(rxq.pop_front());
    upd_rx();
  endtask

  task automatic run_until_wr(input int n, input int budget, input string tag);
    int k = 0;
    while (wr_q.size() < n && k < budget) begin tick(); k++; end
    chk(tag, wr_q.size(), n);
  endtask

  task automatic run_until_state(input logic [2:0] s, input int budget, input string tag);
    int k = 0;
    while (state !== s && k < budget) begin tick(); k++; end
    chk(tag, state, s);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] pend[$];
    logic [7:0] hold_w;
    int e0, nbad, k;

    // Reset with a byte waiting: no pop may happen.
    push_rx(8'h99);
    tick(); tick();
    chk("rst_no_pop", rd_cyc.size(), 0);
    chk("rst_state", state, 0);
    chk("rst_wr", wr_q.size(), 0);
    chk("rst_err", err_ev, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_w_data", w_data, 0);
    rxq.delete(); upd_rx();
    RESET = 1'b1;
    tick();

    // Basic ADD frame and latency.
    clr_logs();
    push_rx(8'h05); push_rx(8'h03); push_rx(8'h20);
    run_until_wr(1, 20, "add_push_seen");
    tick(); tick(); tick();
    chk("add_push_count", wr_q.size(), 1);
    chk("add_data", wr_q[0], 8'h08);
    chk("add_latency", wr_cyc[0] - rd_cyc[2], 2);
    chk("add_state_idle", state, 0);

    // XOR frame held off by tx_full for 10 cycles.
    clr_logs();
    tx_full = 1'b1;
    push_rx(8'h0F); push_rx(8'hF0); push_rx(8'h26);
    run_until_state(3'd4, 20, "xor_reach_send");
    hold_w = w_data;
    nbad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state !== 3'd4 || w_data !== hold_w) nbad++;
    end
    chk("xor_hold_stable", nbad, 0);
    chk("xor_hold_no_push", wr_q.size(), 0);
    tx_full = 1'b0;
    run_until_wr(1, 10, "xor_push_seen");
    chk("xor_data", wr_q[0], 8'hFF);

    // Invalid opcode.
    clr_logs();
    e0 = err_ev;
    push_rx(8'h01); push_rx(8'h02); push_rx(8'h3F);
    for (int i = 0; i < 8; i++) tick();
    chk("bad_err_pulse", err_ev - e0, 1);
    chk("bad_err_cnt", err_cnt, 1);
    chk("bad_no_push", wr_q.size(), 0);
    chk("bad_alu_op_kept", alu_op, 6'h26);
    chk("bad_pops", rd_cyc.size(), 3);
    chk("bad_state", state, 0);

    // Two preloaded frames back to back.
    clr_logs();
    push_rx(8'h10); push_rx(8'h20); push_rx(8'h22);
    push_rx(8'hAA); push_rx(8'h0F); push_rx(8'h24);
    run_until_wr(2, 30, "b2b_push_seen");
    chk("b2b_pops", rd_cyc.size(), 6);
    chk("b2b_f0_consec", (rd_cyc[1] - rd_cyc[0] == 1) && (rd_cyc[2] - rd_cyc[1] == 1), 1);
    chk("b2b_f1_consec", (rd_cyc[4] - rd_cyc[3] == 1) && (rd_cyc[5] - rd_cyc[4] == 1), 1);
    chk("b2b_data0", wr_q[0], 8'hF0);
    chk("b2b_data1", wr_q[1], 8'h0A);
    chk("b2b_gap_ge5", (wr_cyc[1] - wr_cyc[0]) >= 5, 1);

    // Reset while waiting for the opcode.
    clr_logs();
    push_rx(8'h11); push_rx(8'h22);
    run_until_state(3'd2, 10, "mid_reach_getop");
    push_rx(8'h20);
    RESET = 1'b0;
    tick();
    chk("mid_rst_no_pop", rd_cyc.size(), 2);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_a", alu_a, 0);
    chk("mid_rst_b", alu_b, 0);
    chk("mid_rst_op", alu_op, 0);
    chk("mid_rst_w", w_data, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    rxq.delete(); upd_rx();
    RESET = 1'b1;
    tick();
    clr_logs();
    push_rx(8'h07); push_rx(8'h09); push_rx(8'h22);
    run_until_wr(1, 20, "mid_after_push");
    chk("mid_after_data", wr_q[0], 8'hFE);

`ifdef ALU_FRAME_TIMEOUT_EN
    // One byte then a stall of TIMEOUT_CYC cycles aborts the frame.
    clr_logs();
    e0 = err_ev;
    push_rx(8'h33);
    run_until_state(3'd1, 10, "tmo_reach_getb");
    for (int i = 0; i < TO; i++) tick();
    chk("tmo_err_pulse", err_ev - e0, 1);
    chk("tmo_state", state, 0);
    chk("tmo_err_cnt", err_cnt, 1);
    push_rx(8'h04); push_rx(8'h05); push_rx(8'h20);
    run_until_wr(1, 20, "tmo_after_push");
    chk("tmo_after_data", wr_q[0], 8'h09);
`endif

    // Randomized frames with random RX gaps and TX backpressure.
    clr_logs();
    e0 = err_ev;
    exp_q.delete();
    nbad = 0;
    begin
      logic [7:0] err_base;
      err_base = err_cnt;
      for (int f = 0; f < 30; f++) begin
        logic [7:0] a, b, o;
        a = 8'($urandom);
        b = 8'($urandom);
        o = ($urandom_range(0, 3) != 0) ? {2'($urandom), valid_ops[$urandom_range(0, 7)]} : 8'($urandom);
        pend.push_back(a); pend.push_back(b); pend.push_back(o);
        if (op_valid(o)) exp_q.push_back(alu_f(a, b, o[5:0]));
        else nbad++;
      end
      k = 0;
      while ((pend.size() > 0 || rxq.size() > 0 || state !== 3'd0) && k < 3000) begin
        if (pend.size() > 0 && $urandom_range(0, 1) == 1) push_rx(pend.pop_front());
        tx_full = ($urandom_range(0, 2) == 0);
        tick();
        k++;
      end
      tx_full = 1'b0;
      tick(); tick();
      chk("rnd_drained", k < 3000, 1);
      chk("rnd_push_count", wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
        chk($sformatf("rnd_data%0d", i), wr_q[i], exp_q[i]);
      chk("rnd_err_pulses", err_ev - e0, nbad);
      chk("rnd_err_cnt", err_cnt, 8'(err_base + 8'(nbad)));
    end
    chk("never_rd_and_wr", both_ev, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
